// File: rtl/opg_par.sv
// Parametrised OFDM pilot/PN burst generator, DW LFSR bits per word.
// Define OPG_SEED_LOAD_EN to enable runtime seed loading.
module opg_par #(
  parameter int                LFSR_W    = 7,
  parameter logic [LFSR_W-1:0] TAPS      = 7'b1001000,
  parameter int                DW        = 1,
  parameter int                BURST_LEN = 127,
  parameter logic [LFSR_W-1:0] SEED_RST  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              cont,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              out_rdy,
  output logic [DW-1:0]     dout,
  output logic              do_vld,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [LFSR_W-1:0] s;
  logic [LFSR_W-1:0] seed_reg;
  logic [LFSR_W-1:0] seed_src;
  logic [LFSR_W-1:0] src;
  logic [LFSR_W-1:0] nxt;
  logic [DW-1:0]     word;
  logic [CW-1:0]     wcnt;

`ifdef OPG_SEED_LOAD_EN
  logic seed_ok;
  assign seed_ok = seed_ld && (seed != '0);

  always_ff @(posedge clk) begin
    if (rst)
      seed_reg <= SEED_RST;
    else if (state == IDLE && seed_ok)
      seed_reg <= seed;
  end

  // same-cycle load and start uses the new seed directly
  assign seed_src = seed_ok ? seed : seed_reg;
`else
  logic unused_seed;
  assign unused_seed = ^{seed_ld, seed};
  assign seed_reg    = SEED_RST;
  assign seed_src    = seed_reg;
`endif

  assign src = (state == IDLE && !cont) ? seed_src : s;

  always_comb begin
    logic [LFSR_W-1:0] st;
    logic              fb;
    st   = src;
    fb   = 1'b0;
    word = '0;
    for (int k = 0; k < DW; k++) begin
      fb      = ^(st & TAPS);
      word[k] = fb;
      st      = {st[LFSR_W-2:0], fb};
    end
    nxt = st;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s      <= SEED_RST;
      wcnt   <= '0;
      dout   <= '0;
      do_vld <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_en) begin
            state  <= RUN;
            dout   <= word;
            s      <= nxt;
            wcnt   <= '0;
            do_vld <= 1'b1;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (out_rdy) begin
            if (wcnt == LAST) begin
              state  <= IDLE;
              do_vld <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              dout <= word;
              s    <= nxt;
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opg_par.sv
// Self-checking bench for opg_par: vector table, directed
// bursts and a randomized run against a bit-history model.
module tb_opg_par;

  localparam int         W  = 7;
  localparam logic [6:0] TP = 7'b1001000;
  localparam logic [6:0] SR = 7'h7f;

  logic       clk = 1'b0;
  logic       rst, rd_en, cont, seed_ld, out_rdy;
  logic [6:0] seed;

  always #5 clk = ~clk;

  logic [0:0] d0, d2, d3;
  logic [7:0] d1;
  logic v0, b0, n0, v1, b1, n1;
  logic v2, b2, n2, v3, b3, n3;

  int n_cmp = 0;
  int n_bad = 0;

  bit mq[$];

  opg_par u0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .cont(cont),
    .seed_ld(seed_ld), .seed(seed), .out_rdy(out_rdy),
    .dout(d0), .do_vld(v0), .busy(b0), .done(n0)
  );

  opg_par #(.DW(8), .BURST_LEN(4)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .cont(cont),
    .seed_ld(seed_ld), .seed(seed), .out_rdy(out_rdy),
    .dout(d1), .do_vld(v1), .busy(b1), .done(n1)
  );

  opg_par #(.DW(1), .BURST_LEN(16)) u2 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .cont(cont),
    .seed_ld(seed_ld), .seed(seed), .out_rdy(out_rdy),
    .dout(d2), .do_vld(v2), .busy(b2), .done(n2)
  );

  opg_par #(.DW(1), .BURST_LEN(4)) u3 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .cont(cont),
    .seed_ld(seed_ld), .seed(seed), .out_rdy(out_rdy),
    .dout(d3), .do_vld(v3), .busy(b3), .done(n3)
  );

  typedef struct {
    logic rd, ct, rdy;
    logic ev, eb, en, cd, ed;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(logic rd, logic ct, logic rdy,
                              logic ev, logic eb, logic en,
                              logic cd, logic ed);
    vec_t v;
    v.rd = rd; v.ct = ct; v.rdy = rdy;
    v.ev = ev; v.eb = eb; v.en = en;
    v.cd = cd; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // output bit t = XOR of taps over earlier outputs t-1-i;
  // the seed supplies the virtual history before t=0
  function automatic void m_seed(logic [6:0] sd);
    mq.delete();
    for (int j = W - 1; j >= 0; j--) mq.push_back(sd[j]);
  endfunction

  function automatic logic m_bit();
    logic [6:0] tp;
    bit b;
    tp = TP;
    b  = 1'b0;
    for (int i = 0; i < W; i++)
      if (tp[i]) b ^= mq[mq.size() - 1 - i];
    mq.push_back(b);
    void'(mq.pop_front());
    return b;
  endfunction

  function automatic logic [7:0] m_word(int n);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k] = m_bit();
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_en = 1'b0; cont = 1'b0;
    seed_ld = 1'b0; seed = '0; out_rdy = 1'b1;
    tick();
    rst = 1'b0;
    m_seed(SR);
  endtask

  task automatic burst0(input logic ct,
                        output logic [126:0] bits,
                        output int nv, output int nd);
    bits = '0;
    rd_en = 1'b1; cont = ct; out_rdy = 1'b1;
    tick();
    rd_en = 1'b0; cont = 1'b0;
    nv = 0; nd = 0;
    for (int k = 0; k < 140; k++) begin
      if (v0) begin
        if (nv < 127) bits[nv] = d0[0];
        nv++;
      end
      if (n0) nd++;
      tick();
    end
  endtask

  logic [126:0] ba, bb, mexp;
  int           nva, nda, nvb, ndb;

  initial begin
    do_reset();
    chk("rst_dout", d0, 0);
    chk("rst_vld", v0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", n0, 0);
    chk("rst_dout8", d1, 0);
    chk("rst_vld8", v1, 0);

    // cont=0 burst, done+rd_en restart, stall, cont=1, ignored rd_en
    tv[0]  = mk(1, 0, 1, 1, 1, 0, 1, 0);
    tv[1]  = mk(0, 0, 1, 1, 1, 0, 1, 0);
    tv[2]  = mk(0, 0, 1, 1, 1, 0, 1, 0);
    tv[3]  = mk(0, 0, 1, 1, 1, 0, 1, 0);
    tv[4]  = mk(0, 0, 1, 0, 0, 1, 0, 0);
    tv[5]  = mk(1, 1, 1, 1, 1, 0, 1, 1);
    tv[6]  = mk(0, 0, 0, 1, 1, 0, 1, 1);
    tv[7]  = mk(0, 0, 1, 1, 1, 0, 1, 1);
    tv[8]  = mk(0, 0, 1, 1, 1, 0, 1, 1);
    tv[9]  = mk(0, 0, 1, 1, 1, 0, 1, 0);
    tv[10] = mk(0, 0, 1, 0, 0, 1, 0, 0);
    tv[11] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tv[12] = mk(1, 0, 1, 1, 1, 0, 1, 0);
    tv[13] = mk(1, 0, 0, 1, 1, 0, 1, 0);
    tv[14] = mk(1, 1, 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      rd_en = tv[i].rd; cont = tv[i].ct; out_rdy = tv[i].rdy;
      tick();
      chk($sformatf("tbl%0d_vld", i), v3, tv[i].ev);
      chk($sformatf("tbl%0d_busy", i), b3, tv[i].eb);
      chk($sformatf("tbl%0d_done", i), n3, tv[i].en);
      if (tv[i].cd)
        chk($sformatf("tbl%0d_dout", i), d3, tv[i].ed);
    end

    // default burst, then identical cont=0 repeat
    do_reset();
    burst0(1'b0, ba, nva, nda);
    mexp = '0;
    for (int k = 0; k < 127; k++) mexp[k] = m_bit();
    chk("b0_first8", ba[7:0], 8'h70);
    chk("b0_model", ba == mexp, 1);
    chk("b0_nvld", nva, 127);
    chk("b0_ndone", nda, 1);
    burst0(1'b0, bb, nvb, ndb);
    chk("b0_repeat", bb == ba, 1);
    chk("b0_ndone2", ndb, 1);

    // DW=8, BURST_LEN=4
    do_reset();
    rd_en = 1'b1; cont = 1'b0;
    tick();
    rd_en = 1'b0;
    chk("w8_first", d1, 8'h70);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("w8_vld%0d", w), v1, 1);
      chk($sformatf("w8_word%0d", w), d1, m_word(8));
      tick();
    end
    chk("w8_done", n1, 1);
    chk("w8_vld_end", v1, 0);
    chk("w8_busy_end", b1, 0);

    // DW=1, BURST_LEN=16 with 3-cycle stall on word 5
    do_reset();
    begin
      logic [15:0] got, ex;
      logic        hold;
      int          nv, kd;
      ex = '0;
      for (int k = 0; k < 16; k++) ex[k] = m_bit();
      got = '0; nv = 0; kd = -1; hold = 1'b0;
      rd_en = 1'b1; cont = 1'b0; out_rdy = 1'b1;
      tick();
      rd_en = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (k == 4) hold = d2[0];
        if (k >= 5 && k <= 7)
          chk($sformatf("st_hold%0d", k), d2, hold);
        if (n2 && kd < 0) kd = k;
        out_rdy = !(k >= 4 && k <= 6);
        if (v2 && out_rdy) begin
          if (nv < 16) got[nv] = d2[0];
          nv++;
        end
        tick();
      end
      out_rdy = 1'b1;
      chk("st_seq", got, ex);
      chk("st_nacc", nv, 16);
      chk("st_done_at", kd, 19);
    end

    // reset during word 10 of 127
    do_reset();
    rd_en = 1'b1; cont = 1'b0;
    tick();
    rd_en = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("mr_vld_pre", v0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_vld", v0, 0);
    chk("mr_busy", b0, 0);
    chk("mr_done", n0, 0);
    chk("mr_dout", d0, 0);
    tick();
    chk("mr_done2", n0, 0);
    burst0(1'b0, ba, nva, nda);
    chk("mr_first8", ba[7:0], 8'h70);
    chk("mr_ndone", nda, 1);

`ifdef OPG_SEED_LOAD_EN
    do_reset();
    seed_ld = 1'b1; seed = 7'h01;
    tick();
    seed_ld = 1'b0;
    burst0(1'b0, ba, nva, nda);
    chk("sl_first7", ba[6:0], 7'h48);
    seed_ld = 1'b1; seed = 7'h00;
    tick();
    seed_ld = 1'b0;
    burst0(1'b0, ba, nva, nda);
    chk("sl_zero", ba[3:0], 4'h8);
`endif

    // randomized traffic on the default instance
    do_reset();
    begin
      bit m_busy, m_done;
      logic m_w;
      int m_cnt;
      m_busy = 0; m_done = 0; m_w = 0; m_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
        chk("rnd_vld", v0, m_busy);
        chk("rnd_busy", b0, m_busy);
        chk("rnd_done", n0, m_done);
        if (m_busy) chk("rnd_dout", d0, m_w);
        rd_en   = ($urandom_range(0, 3) == 0);
        cont    = $urandom_range(0, 1);
        out_rdy = ($urandom_range(0, 3) != 0);
        m_done  = 0;
        if (!m_busy) begin
          if (rd_en) begin
            if (!cont) m_seed(SR);
            m_w = m_bit();
            m_cnt = 1;
            m_busy = 1;
          end
        end else if (out_rdy) begin
          if (m_cnt == 127) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_w = m_bit();
            m_cnt++;
          end
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opg_par.md
# opg_par

Parametrised OFDM pilot/PN-sequence generator; successor to the single-bit OPG. On a `rd_en` start pulse it emits a burst of `BURST_LEN` words, each `DW` bits wide, from a configurable Fibonacci LFSR, with `out_rdy` backpressure. It also supports a continue-sequence mode and an optional runtime seed load. It sits between the frame controller and the pilot-insertion stage of the OFDM transmitter.

## Interface
- `LFSR_W`, 7, LFSR length in bits (≥2).
- `TAPS`, 7'b1001000, feedback tap mask; bit i set means `s[i]` is XORed into feedback. The default is x^7+x^4+1.
- `DW`, 1, bits per output word (1..32).
- `BURST_LEN`, 127, words per burst (≥1).
- `SEED_RST`, all-ones, seed register reset value; must be nonzero.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `rd_en` in 1 — burst start request, sampled in IDLE only.
- `cont` in 1 — sampled with `rd_en`:
  - 1: continue from the current LFSR state.
  - 0: reload the LFSR from the seed register.
- `seed_ld` in 1 — seed register load strobe; effective only with `OPG_SEED_LOAD_EN`.
- `seed` in LFSR_W — value for the seed load.
- `out_rdy` in 1 — downstream ready.
- `do` out DW — output word; the first-generated bit is in `do[0]`.
- `do_vld` out 1 — `do` is valid.
- `busy` out 1 — high in RUN.
- `done` out 1 — one-cycle pulse when the last word is accepted.

## Operation
- State register `s[LFSR_W-1:0]`.
- Per bit: `fb = ^(s & TAPS)`. The output bit is `fb`, and the next state is `s = {s[LFSR_W-2:0], fb}`.
- Each word is DW bit steps unrolled combinationally: bit k is produced after k prior steps.
- FSM states are IDLE and RUN.
- IDLE:
  - `rd_en=1` → RUN.
  - The source state is `seed_reg` when `cont=0`, or `s` when `cont=1`.
  - The first word is generated from the source state and registered into `do`.
  - `s` advances by DW steps.
  - The word counter `wcnt` is set to 0.
- RUN:
  - `do_vld=1`.
  - Handshake is `do_vld & out_rdy`.
  - On a handshake with `wcnt < BURST_LEN-1`: the next word is loaded into `do`, `s` advances by DW steps, and `wcnt` increments.
  - On a handshake with `wcnt == BURST_LEN-1`: go to IDLE, set `do_vld=0`, pulse `done` for 1 cycle, and leave `s` unchanged. There is no look-ahead word.
- `out_rdy=0`: `do`, `s` and `wcnt` all hold. No bit is ever skipped or repeated.
- `rd_en` in RUN is ignored; it is not queued.
- `wcnt` width is `$clog2(BURST_LEN+1)`.
- `cont=1` after reset continues from `s`, which is the reset seed.

## Timing
- Reset values:
  - `do=0`, `do_vld=0`, `busy=0`, `done=0`.
  - state IDLE, `wcnt=0`.
  - `s = SEED_RST`, `seed_reg = SEED_RST`.
- `rd_en` sampled at edge N → `do_vld=busy=1` and the first word on `do` after edge N.
- Throughput is 1 word/cycle while `out_rdy=1`.
- A burst with `out_rdy` held high:
  - `do_vld` is high for exactly BURST_LEN cycles.
  - `done` is high in the cycle after the final accepting edge, and `busy` is low in that same cycle.
- `rd_en` in the same cycle that `done` is high starts a new burst: 1 cycle gap minimum.
- `rst` mid-burst: the next cycle shows reset values. A partial burst is discarded, and no `done` is issued.
- Output data is fully registered; there is no combinational path from `out_rdy` to `do`.

## Configuration
- `OPG_SEED_LOAD_EN` defined:
  - `seed_ld=1` in IDLE loads `seed_reg <= seed`.
  - `seed==0` is ignored, because an all-zero LFSR locks up.
  - `seed_ld` in RUN is ignored.
  - `seed_ld` and `rd_en` in the same IDLE cycle: the new seed takes effect, and a `cont=0` burst uses `seed` directly.
- Not defined: `seed_ld` and `seed` are ignored, and `seed_reg` is constant `SEED_RST`.

## Test plan
- Default parameters, `rd_en` pulse, `out_rdy=1`:
  - The first 8 `do` bits are 0,0,0,0,1,1,1,0.
  - 127 valid cycles, `done` pulses once.
  - A second `cont=0` burst is bit-identical to the first.
- DW=8, BURST_LEN=4, `cont=0` → first word 8'h70.
- DW=1, BURST_LEN=16, `out_rdy` low for 3 cycles after the 5th word:
  - `do` is held stable while stalled.
  - The total sequence equals the unstalled reference.
  - `done` is delayed by 3 cycles.
- DW=1, BURST_LEN=4: a `cont=0` burst gives 0,0,0,0; a following `cont=1` burst gives 1,1,1,0.
- `OPG_SEED_LOAD_EN`:
  - `seed_ld` with `seed=7'h01`, then a `cont=0` burst → first 7 bits 0,0,0,1,0,0,1.
  - `seed_ld` with `seed=0` is ignored, and the next burst starts 0,0,0,1.
- `rst` asserted during word 10 of 127 → the next cycle shows `do_vld=0`, `busy=0`, `done=0`. The next burst restarts from `SEED_RST`: 0,0,0,0,1,1,1,0.
